// File: rtl/uart_tx_param_if.sv
// Producer-side handshake for the parametrised UART transmitter.
// The master drives start/data; the slave (transmitter) drives the line and status.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_srt;
    logic [DATA_BITS-1:0] din;
    logic                 tx_reg;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_srt,
        output din,
        input  tx_reg,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_srt,
        input  din,
        output tx_reg,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional
// odd/even parity, 1 or 2 stop bits; registered idle-high line and done pulse.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_param_if.slave  bus
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
        $error("uart_tx_param: illegal parameter combination");
    end

    logic [2:0]           state_q,  state_d;
    logic [BAUD_W-1:0]    baud_q,   baud_d;
    logic [BIT_W-1:0]     bit_q,    bit_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 tx_reg_q, tx_reg_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    logic                 baud_tick;
    logic [BIT_W-1:0]     next_idx;
    logic                 par_bit;

    assign baud_tick = (baud_q == BAUD_LAST);
    assign next_idx  = bit_q + 1'b1;
    // Parity comes from the word captured at accept, so live din is irrelevant.
    assign par_bit   = (PARITY == 1) ? ~(^data_q) : (^data_q);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        data_d   = data_q;
        tx_reg_d = tx_reg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_reg_d = 1'b1;
                busy_d   = 1'b0;
                baud_d   = '0;
                bit_d    = '0;
                if (bus.tx_srt) begin
                    data_d   = bus.din;
                    state_d  = S_START;
                    tx_reg_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d  = S_DATA;
                    bit_d    = '0;
                    tx_reg_d = data_q[0];
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d  = S_PARITY;
                            tx_reg_d = par_bit;
                        end else begin
                            state_d  = S_STOP;
                            tx_reg_d = 1'b1;
                        end
                    end else begin
                        bit_d    = next_idx;
                        tx_reg_d = data_q[next_idx];
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    state_d  = S_STOP;
                    bit_d    = '0;
                    tx_reg_d = 1'b1;
                end
            end
            S_STOP: begin
                // bit_q doubles as the stop-bit counter for two-stop-bit frames.
                if (baud_tick) begin
                    if (bit_q == STOP_LAST) begin
                        state_d  = S_IDLE;
                        bit_d    = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        tx_reg_d = 1'b1;
                    end else begin
                        bit_d = next_idx;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                baud_d   = '0;
                bit_d    = '0;
                tx_reg_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            tx_reg_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            tx_reg_q <= tx_reg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.tx_reg  = tx_reg_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Drives four transmitter configurations (8N1, 8E1, 8O1, 7N2 at 4 clocks/bit)
// with shared stimulus and compares every cycle against a frame-level model.
module tb_uart_tx_param;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       srt = 1'b0;
    logic [8:0] din_s = '0;

    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_BITS(8)) if_a ();
    uart_tx_param_if #(.DATA_BITS(8)) if_b ();
    uart_tx_param_if #(.DATA_BITS(8)) if_c ();
    uart_tx_param_if #(.DATA_BITS(7)) if_d ();

    assign if_a.tx_srt = srt;
    assign if_b.tx_srt = srt;
    assign if_c.tx_srt = srt;
    assign if_d.tx_srt = srt;
    assign if_a.din    = din_s[7:0];
    assign if_b.din    = din_s[7:0];
    assign if_c.din    = din_s[7:0];
    assign if_d.din    = din_s[6:0];

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));

    logic [3:0] obs_reg, obs_busy, obs_done;
    assign obs_reg  = {if_d.tx_reg,  if_c.tx_reg,  if_b.tx_reg,  if_a.tx_reg};
    assign obs_busy = {if_d.tx_busy, if_c.tx_busy, if_b.tx_busy, if_a.tx_busy};
    assign obs_done = {if_d.tx_done, if_c.tx_done, if_b.tx_done, if_a.tx_done};

    int checks = 0;
    int errors = 0;

    // Model: pos = -1 idle; 1..F*CPB inside frame; F*CPB+1 is the done cycle.
    int   pos  [4];
    int   flen [4];
    logic frm  [4][16];

    function automatic int cfg_db(input int i);
        return (i == 3) ? 7 : 8;
    endfunction

    function automatic int cfg_par(input int i);
        if (i == 1) return 2;
        if (i == 2) return 1;
        return 0;
    endfunction

    function automatic int cfg_stop(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic build_frame(input int i, input logic [8:0] d);
        int n;
        int ones;
        n    = 1;
        ones = 0;
        frm[i][0] = 1'b0;
        for (int b = 0; b < cfg_db(i); b++) begin
            frm[i][n] = d[b];
            ones += int'(d[b]);
            n++;
        end
        if (cfg_par(i) == 2) begin
            frm[i][n] = ((ones % 2) == 1);
            n++;
        end else if (cfg_par(i) == 1) begin
            frm[i][n] = ((ones % 2) == 0);
            n++;
        end
        for (int s = 0; s < cfg_stop(i); s++) begin
            frm[i][n] = 1'b1;
            n++;
        end
        flen[i] = n;
    endtask

    // One clock cycle: check outputs of the current cycle, then apply new inputs
    // and advance the model to the next cycle.
    task automatic step(input logic r, input logic s, input logic [8:0] d);
        logic er, eb, ed;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (pos[i] < 0) begin
                er = 1'b1; eb = 1'b0; ed = 1'b0;
            end else if (pos[i] <= flen[i] * CPB) begin
                er = frm[i][(pos[i] - 1) / CPB]; eb = 1'b1; ed = 1'b0;
            end else begin
                er = 1'b1; eb = 1'b0; ed = 1'b1;
            end
            check_val($sformatf("cfg%0d_tx_reg", i),  32'(obs_reg[i]),  32'(er));
            check_val($sformatf("cfg%0d_tx_busy", i), 32'(obs_busy[i]), 32'(eb));
            check_val($sformatf("cfg%0d_tx_done", i), 32'(obs_done[i]), 32'(ed));
        end
        rst   = r;
        srt   = s;
        din_s = d;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                pos[i] = -1;
            end else if (pos[i] < 0 || pos[i] == flen[i] * CPB + 1) begin
                if (s) begin
                    build_frame(i, d);
                    pos[i] = 1;
                    if (i == 0) $display("frame accepted din=%03h at %0t", d, $time);
                end else begin
                    pos[i] = -1;
                end
            end else begin
                pos[i] = pos[i] + 1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            pos[i]  = -1;
            flen[i] = 10;
        end

        repeat (3) step(1'b1, 1'b0, 9'h000);

        step(1'b0, 1'b1, 9'h0AA);
        repeat (60) step(1'b0, 1'b0, 9'h0AA);
        step(1'b0, 1'b1, 9'h007);
        repeat (60) step(1'b0, 1'b0, 9'h007);
        step(1'b0, 1'b1, 9'h055);
        repeat (60) step(1'b0, 1'b0, 9'h055);

        repeat (150) step(1'b0, 1'b1, 9'h0AA);
        repeat (60) step(1'b0, 1'b0, 9'h000);

        // Abort during data bit 3, then a clean frame.
        step(1'b0, 1'b1, 9'h05A);
        repeat (17) step(1'b0, 1'b0, 9'h05A);
        step(1'b1, 1'b0, 9'h05A);
        repeat (5) step(1'b0, 1'b0, 9'h000);
        step(1'b0, 1'b1, 9'h03C);
        repeat (60) step(1'b0, 1'b0, 9'h03C);

        // Reset together with a start request: no frame.
        step(1'b1, 1'b1, 9'h0F0);
        repeat (10) step(1'b0, 1'b0, 9'h000);

        // Mid-frame din change and start pulse are ignored.
        step(1'b0, 1'b1, 9'h012);
        repeat (20) step(1'b0, 1'b0, 9'h012);
        step(1'b0, 1'b1, 9'h0FF);
        repeat (40) step(1'b0, 1'b0, 9'h0FF);

        for (int n = 0; n < 2500; n++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, 9'($urandom));
        end
        repeat (60) step(1'b0, 1'b0, 9'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
